// File: rtl/nco_pkg.sv
// Shared constants for the NCO phase accumulator family: default widths,
// cfg_sel encodings and the dither LFSR polynomial/seed.
package nco_pkg;

    localparam int unsigned ACC_W_DEF = 26;
    localparam int unsigned OUT_W_DEF = 14;

    localparam logic CFG_FREQ  = 1'b0;
    localparam logic CFG_PHASE = 1'b1;

    // x^16 + x^14 + x^13 + x^11 + 1, taps on state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/nco_lfsr.sv
// 16-bit Fibonacci LFSR with enable; used as the phase-dither source.
module nco_lfsr
    import nco_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LFSR_SEED;
        end else if (en) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/nco_phase_mc.sv
// Time-multiplexed multi-channel NCO phase accumulator, one channel per clk.
// Optional phase dither enabled by defining PHASE_DITHER_EN.
module nco_phase_mc
    import nco_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned NCH   = 4,
    parameter int unsigned CH_W  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [ACC_W-1:0] cfg_data,
    output logic             cfg_ready,
    input  logic             commit,
    output logic             commit_done,
    output logic             ph_valid,
    output logic [CH_W-1:0]  ph_ch,
    output logic [OUT_W-1:0] ph_out,
    output logic             ph_wrap
);

    logic [CH_W-1:0]  ch_idx_q;
    logic [ACC_W-1:0] acc_q      [NCH];
    logic [ACC_W-1:0] freq_sh_q  [NCH];
    logic [ACC_W-1:0] ph_sh_q    [NCH];
    logic [ACC_W-1:0] freq_act_q [NCH];
    logic [ACC_W-1:0] ph_act_q   [NCH];
    logic             pending_q;

    logic             last_slot;
    logic             transfer;
    logic             cfg_wr;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] ph_sum;
    logic             unused_ph_lsbs;

    assign last_slot = (ch_idx_q == CH_W'(NCH - 1));
    assign transfer  = pending_q & last_slot;
    assign cfg_ready = ~pending_q;
    assign cfg_wr    = cfg_we & ~pending_q;

    // Single shared adder: the slot's channel is the only one touched this cycle.
    assign acc_sum = {1'b0, acc_q[ch_idx_q]} + {1'b0, freq_act_q[ch_idx_q]};

`ifdef PHASE_DITHER_EN
    localparam int unsigned DITH_W = ((ACC_W - OUT_W) < 16) ? (ACC_W - OUT_W) : 16;

    logic [15:0] lfsr;
    logic        unused_lfsr;

    nco_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .state (lfsr)
    );

    assign ph_sum      = acc_q[ch_idx_q] + ph_act_q[ch_idx_q] + ACC_W'(lfsr[DITH_W-1:0]);
    assign unused_lfsr = ^lfsr;
`else
    assign ph_sum = acc_q[ch_idx_q] + ph_act_q[ch_idx_q];
`endif

    assign unused_ph_lsbs = ^ph_sum[ACC_W-OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_idx_q    <= '0;
            pending_q   <= 1'b0;
            commit_done <= 1'b0;
            ph_valid    <= 1'b0;
            ph_ch       <= '0;
            ph_out      <= '0;
            ph_wrap     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]      <= '0;
                freq_sh_q[i]  <= '0;
                ph_sh_q[i]    <= '0;
                freq_act_q[i] <= '0;
                ph_act_q[i]   <= '0;
            end
        end else begin
            ch_idx_q        <= ch_idx_q + CH_W'(1);
            acc_q[ch_idx_q] <= acc_sum[ACC_W-1:0];
            ph_valid        <= 1'b1;
            ph_ch           <= ch_idx_q;
            ph_out          <= ph_sum[ACC_W-1 -: OUT_W];
            ph_wrap         <= acc_sum[ACC_W];
            commit_done     <= transfer;

            if (cfg_wr) begin
                if (cfg_sel == CFG_FREQ) begin
                    freq_sh_q[cfg_ch] <= cfg_data;
                end else begin
                    ph_sh_q[cfg_ch] <= cfg_data;
                end
            end

            // Slot NCH-1 above still reads the old active values on this edge.
            if (transfer) begin
                pending_q  <= 1'b0;
                freq_act_q <= freq_sh_q;
                ph_act_q   <= ph_sh_q;
            end else if (commit) begin
                pending_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_mc.sv
// Self-checking bench for nco_phase_mc: directed scenarios plus random traffic
// compared against an arithmetic reference model of the channel set.
module tb_nco_phase_mc;

    localparam int    ACC_W = 26;
    localparam int    OUT_W = 14;
    localparam int    NCH   = 4;
    localparam int    CH_W  = 2;
    localparam longint MOD  = 64'd1 << ACC_W;
    localparam longint LSB  = 64'd1 << (ACC_W - OUT_W);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_we = 1'b0;
    logic             cfg_sel = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [ACC_W-1:0] cfg_data = '0;
    logic             cfg_ready;
    logic             commit = 1'b0;
    logic             commit_done;
    logic             ph_valid;
    logic [CH_W-1:0]  ph_ch;
    logic [OUT_W-1:0] ph_out;
    logic             ph_wrap;

    nco_phase_mc #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .NCH   (NCH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_ch      (cfg_ch),
        .cfg_data    (cfg_data),
        .cfg_ready   (cfg_ready),
        .commit      (commit),
        .commit_done (commit_done),
        .ph_valid    (ph_valid),
        .ph_ch       (ph_ch),
        .ph_out      (ph_out),
        .ph_wrap     (ph_wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: per-channel values as plain integers.
    longint m_acc [NCH];
    longint m_fsh [NCH];
    longint m_psh [NCH];
    longint m_fact[NCH];
    longint m_pact[NCH];
    int     m_slot;
    bit     m_pend;
    logic [15:0] m_lfsr;

    // Expected outputs of the most recent step.
    int     e_ch;
    bit     e_done;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit we, input bit sel, input int ch, input longint data,
                        input bit cm, input bit rst);
        longint a, s, dith, e_out;
        bit     e_wrap, e_valid;
        int     c;
        @(negedge clk);
        reset    = rst;
        cfg_we   = we;
        cfg_sel  = sel;
        cfg_ch   = CH_W'(ch);
        cfg_data = ACC_W'(data);
        commit   = cm;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0; m_fsh[i] = 0; m_psh[i] = 0; m_fact[i] = 0; m_pact[i] = 0;
            end
            m_slot = 0; m_pend = 0; m_lfsr = 16'hACE1;
            e_out = 0; e_wrap = 0; e_valid = 0; e_ch = 0; e_done = 0;
        end else begin
            c    = m_slot;
            a    = m_acc[c];
            dith = 0;
`ifdef PHASE_DITHER_EN
            dith   = longint'(m_lfsr) % LSB;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
            s        = a + m_fact[c];
            e_wrap   = (s >= MOD);
            m_acc[c] = s % MOD;
            e_out    = ((a + m_pact[c] + dith) % MOD) / LSB;
            e_ch     = c;
            e_valid  = 1;
            e_done   = 0;
            if (we && !m_pend) begin
                if (!sel) m_fsh[ch] = data; else m_psh[ch] = data;
            end
            if (m_pend && c == NCH - 1) begin
                for (int i = 0; i < NCH; i++) begin
                    m_fact[i] = m_fsh[i];
                    m_pact[i] = m_psh[i];
                end
                m_pend = 0;
                e_done = 1;
            end else if (cm) begin
                m_pend = 1;
            end
            m_slot = (c + 1) % NCH;
        end
        check_eq("ph_valid", longint'(ph_valid), longint'(e_valid));
        check_eq("ph_ch", longint'(ph_ch), longint'(e_ch));
        check_eq("ph_out", longint'(ph_out), e_out);
        check_eq("ph_wrap", longint'(ph_wrap), longint'(e_wrap));
        check_eq("commit_done", longint'(commit_done), longint'(e_done));
        check_eq("cfg_ready", longint'(cfg_ready), longint'(!m_pend));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    int k0, k2;
    bit done_seen;

    initial begin
        // Reset state.
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Scenarios 1-3 together: freq ch0=2^20, freq ch2=2^25, phase ch1=2^24.
        step(1, 0, 0, 64'd1 << 20, 0, 0);
        step(1, 0, 2, 64'd1 << 25, 0, 0);
        step(1, 1, 1, 64'd1 << 24, 1, 0);
        done_seen = 0; k0 = 0; k2 = 0;
        for (int i = 0; i < 32; i++) begin
            idle();
`ifndef PHASE_DITHER_EN
            if (done_seen) begin
                case (e_ch)
                    0: begin check_eq("ch0_step", longint'(ph_out), 256 * k0); k0++; end
                    1: begin
                        check_eq("ch1_const", longint'(ph_out), 4096);
                        check_eq("ch1_nowrap", longint'(ph_wrap), 0);
                    end
                    2: begin
                        check_eq("ch2_alt", longint'(ph_out), (k2 % 2) * 8192);
                        check_eq("ch2_wrap", longint'(ph_wrap), k2 % 2);
                        k2++;
                    end
                    default: check_eq("ch3_zero", longint'(ph_out), 0);
                endcase
            end
`endif
            if (e_done) done_seen = 1;
        end

        // Scenario 4: write all channels, commit at slot 1, try a write while pending.
        for (int c = 0; c < NCH; c++) step(1, 0, c, 64'd1000 * (c + 1), 0, 0);
        while (m_slot != 1) idle();
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 3, 64'h3FFFFFF, 0, 0);
        for (int i = 0; i < 12; i++) idle();

        // Scenario 5: mid-run reset pulse, then restart at channel 0.
        step(0, 0, 0, 0, 0, 1);
        idle();
        check_eq("restart_ch0", longint'(ph_ch), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 3) == 0, $urandom % 2, $urandom % NCH,
                 (($urandom % 4) == 0) ? longint'($urandom % 4096) : longint'($urandom) % MOD,
                 ($urandom % 8) == 0, ($urandom % 300) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
